// File: rtl/bitwise_serial_rx.sv
// bitwise_serial_rx: bit-serial receiver for the 4-bit bitwise logic path.
// Two operands arrive one bit pair per clock. Each pair is combined with the
// operation latched at start (AND/OR/XOR/NAND). The 4-bit result is published
// on o0..o3 only when the word is complete, and done pulses for one cycle.
//
// Optional feature: define BITWISE_SERIAL_PARITY_EN to add the registered
// output 'par' = o0^o1^o2^o3 of each new result.
module bitwise_serial_rx #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       bit_valid,
    input  logic       xs,
    input  logic       ys,
    output logic       busy,
    output logic       done,
    output logic       o0,
    output logic       o1,
    output logic       o2,
`ifdef BITWISE_SERIAL_PARITY_EN
    output logic       o3,
    output logic       par
`else
    output logic       o3
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;

    state_t     state;
    logic [1:0] cnt;
    logic [1:0] op_q;
    logic [3:0] sh;
    logic [3:0] sh_next;
    logic [1:0] pos;
    logic       r_bit;

    // Combine the incoming pair and merge it into the partial word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        r_bit   = 1'b0;
        sh_next = sh;
        case (op_q)
            OP_AND:  r_bit = xs & ys;
            OP_OR:   r_bit = xs | ys;
            OP_XOR:  r_bit = xs ^ ys;
            default: r_bit = ~(xs & ys);
        endcase
        pos          = LSB_FIRST ? cnt : (2'd3 - cnt);
        sh_next[pos] = r_bit;
    end

    // Control FSM, shift register and registered result outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            // Reset is sampled on the clock edge and overrides start and the
            // final pair, so an aborted word never produces a done pulse.
            state <= ST_IDLE;
            cnt   <= 2'd0;
            op_q  <= 2'b00;
            sh    <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            {o3, o2, o1, o0} <= 4'd0;
`ifdef BITWISE_SERIAL_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    // bit_valid is deliberately ignored here, even with start.
                    if (start) begin
                        op_q  <= op;
                        cnt   <= 2'd0;
                        sh    <= 4'd0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (bit_valid) begin
                        sh  <= sh_next;
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            // Publish the whole word at once; partial words
                            // never reach the outputs.
                            {o3, o2, o1, o0} <= sh_next;
`ifdef BITWISE_SERIAL_PARITY_EN
                            par   <= ^sh_next;
`endif
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Single-cycle pulse; start is not honoured here.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_serial_rx.sv
// Self-checking bench for bitwise_serial_rx. Two instances share all inputs:
// one built with LSB_FIRST=1 and one with LSB_FIRST=0. Expected results come
// from a word-level model (whole-vector bitwise op, bit-reversed for MSB-first).
module tb_bitwise_serial_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic       bit_valid;
    logic       xs;
    logic       ys;

    logic busy_l, done_l, o0_l, o1_l, o2_l, o3_l;
    logic busy_m, done_m, o0_m, o1_m, o2_m, o3_m;
    logic [3:0] ov_l;
    logic [3:0] ov_m;
`ifdef BITWISE_SERIAL_PARITY_EN
    logic par_l, par_m;
`endif

    assign ov_l = {o3_l, o2_l, o1_l, o0_l};
    assign ov_m = {o3_m, o2_m, o1_m, o0_m};

    int checks = 0;
    int errors = 0;

    // Expected published words (what o3..o0 should hold) for each instance.
    logic [3:0] exp_l = 4'd0;
    logic [3:0] exp_m = 4'd0;

    always #5 clk = ~clk;

    bitwise_serial_rx #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .bit_valid(bit_valid), .xs(xs), .ys(ys),
        .busy(busy_l), .done(done_l),
`ifdef BITWISE_SERIAL_PARITY_EN
        .o0(o0_l), .o1(o1_l), .o2(o2_l), .o3(o3_l), .par(par_l)
`else
        .o0(o0_l), .o1(o1_l), .o2(o2_l), .o3(o3_l)
`endif
    );

    bitwise_serial_rx #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .bit_valid(bit_valid), .xs(xs), .ys(ys),
        .busy(busy_m), .done(done_m),
`ifdef BITWISE_SERIAL_PARITY_EN
        .o0(o0_m), .o1(o1_m), .o2(o2_m), .o3(o3_m), .par(par_m)
`else
        .o0(o0_m), .o1(o1_m), .o2(o2_m), .o3(o3_m)
`endif
    );

    // Word-level reference: x[i], y[i] is the i-th pair received.
    function automatic logic [3:0] model_word(input logic [1:0] m_op,
                                              input logic [3:0] x,
                                              input logic [3:0] y,
                                              input bit lsb);
        logic [3:0] w;
        case (m_op)
            2'b00:   w = x & y;
            2'b01:   w = x | y;
            2'b10:   w = x ^ y;
            default: w = ~(x & y);
        endcase
        return lsb ? w : {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against expectations.
    task automatic check_all(input string tag, input logic eb, input logic ed);
        check({tag, ".busy_l"}, {7'd0, busy_l}, {7'd0, eb});
        check({tag, ".done_l"}, {7'd0, done_l}, {7'd0, ed});
        check({tag, ".o_l"},    {4'd0, ov_l},   {4'd0, exp_l});
        check({tag, ".busy_m"}, {7'd0, busy_m}, {7'd0, eb});
        check({tag, ".done_m"}, {7'd0, done_m}, {7'd0, ed});
        check({tag, ".o_m"},    {4'd0, ov_m},   {4'd0, exp_m});
`ifdef BITWISE_SERIAL_PARITY_EN
        check({tag, ".par_l"},  {7'd0, par_l},  {7'd0, ^exp_l});
        check({tag, ".par_m"},  {7'd0, par_m},  {7'd0, ^exp_m});
`endif
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            start     = 1'b0;
            bit_valid = 1'($urandom);
            xs        = 1'($urandom);
            ys        = 1'($urandom);
            tick();
            check_all("idle", 1'b0, 1'b0);
        end
    endtask

    // Start a word and feed n (<4) pairs, leaving it in progress.
    task automatic partial_word(input logic [1:0] wop, input int n);
        start = 1'b1; op = wop; bit_valid = 1'b1;
        xs = 1'($urandom); ys = 1'($urandom);
        tick();
        check_all("pstart", 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1; xs = 1'($urandom); ys = 1'($urandom);
            tick();
            check_all("ppair", 1'b1, 1'b0);
        end
    endtask

    // Complete word: start cycle, 4 pairs with an optional stall before pair
    // stall_at, then the DONE cycle. inject pulses start (with a different op)
    // during SHIFT and DONE, which must be ignored.
    task automatic run_word(input logic [1:0] wop, input logic [3:0] x, input logic [3:0] y,
                            input int stall_at, input int stall_len, input bit inject);
        start = 1'b1; op = wop; bit_valid = 1'b1;
        xs = 1'($urandom); ys = 1'($urandom);
        tick();
        check_all("start", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    start = inject; op = wop ^ 2'b01; bit_valid = 1'b0;
                    xs = 1'($urandom); ys = 1'($urandom);
                    tick();
                    check_all("stall", 1'b1, 1'b0);
                end
            end
            start = inject; op = wop ^ 2'b01; bit_valid = 1'b1;
            xs = x[i]; ys = y[i];
            tick();
            if (i == 3) begin
                exp_l = model_word(wop, x, y, 1'b1);
                exp_m = model_word(wop, x, y, 1'b0);
                check_all("last_pair", 1'b0, 1'b1);
            end else begin
                check_all("pair", 1'b1, 1'b0);
            end
        end
        start = inject; op = wop ^ 2'b01; bit_valid = 1'($urandom);
        xs = 1'($urandom); ys = 1'($urandom);
        tick();
        check_all("done_exit", 1'b0, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; bit_valid = 1'b0; xs = 1'b0; ys = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 1'b0);
        reset = 1'b0;
        idle_cycles(2);

        // AND, x=1,1,0,1 y=1,0,1,1 in arrival order -> o0..o3 = 1,0,0,1.
        run_word(2'b00, 4'b1011, 4'b1101, 4, 0, 1'b0);
        check("t1.o_l_const", {4'd0, ov_l}, 8'h09);

        // XOR 1010 ^ 0110 with a 2-cycle stall between pairs 2 and 3.
        run_word(2'b10, 4'b1010, 4'b0110, 2, 2, 1'b0);
        check("t2.o_l_const", {4'd0, ov_l}, 8'h0C);

        // NAND, x=1,1,1,1 y=1,0,1,0; MSB-first instance -> o3..o0 = 0101.
        run_word(2'b11, 4'b1111, 4'b0101, 4, 0, 1'b0);
        check("t3.o_m_const", {4'd0, ov_m}, 8'h05);
        idle_cycles(1);

        // Reset after 2 pairs: outputs clear, no done; next word is clean.
        partial_word(2'b01, 2);
        reset = 1'b1; bit_valid = 1'b1; xs = 1'b1; ys = 1'b1;
        tick();
        exp_l = 4'd0; exp_m = 4'd0;
        check_all("rst_mid", 1'b0, 1'b0);
        reset = 1'b0;
        idle_cycles(1);
        run_word(2'b01, 4'b0011, 4'b0101, 1, 1, 1'b0);

        // start/op changes during SHIFT and DONE are ignored.
        run_word(2'b00, 4'b1110, 4'b0111, 1, 2, 1'b1);
        idle_cycles(2);

        // Reset coincident with the 4th pair: reset wins, no done.
        partial_word(2'b10, 3);
        reset = 1'b1; bit_valid = 1'b1; xs = 1'b1; ys = 1'b0;
        tick();
        exp_l = 4'd0; exp_m = 4'd0;
        check_all("rst_last", 1'b0, 1'b0);
        reset = 1'b0;
        idle_cycles(1);
        check_all("rst_last_after", 1'b0, 1'b0);

        // Reset coincident with start: no word begins.
        run_word(2'b01, 4'b1001, 4'b0100, 4, 0, 1'b0);
        reset = 1'b1; start = 1'b1; op = 2'b11;
        tick();
        exp_l = 4'd0; exp_m = 4'd0;
        check_all("rst_start", 1'b0, 1'b0);
        reset = 1'b0; start = 1'b0;
        idle_cycles(1);

        // Back-to-back then randomized words.
        run_word(2'b10, 4'b0110, 4'b1100, 4, 0, 1'b0);
        run_word(2'b11, 4'b1010, 4'b1001, 4, 0, 1'b0);
        for (int n = 0; n < 40; n++) begin
            run_word(2'($urandom), 4'($urandom), 4'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
